fixed_point_addsub_pipe: RTL and testbench
==========================================

Name: fixed_point_addsub_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational Q-format add/sub unit.
- Adds per-operation mode selection, a running accumulator, optional saturation, per-result and sticky overflow flags, and valid/ready flow control.
- Sits in the linear-regressor datapath between the operand sequencer and the gradient/weight-update logic.
- Default format is Q24.8.

Parameters:
- WIDTH, 32, total signed word width in bits.
- FRAC_BITS, 8, fractional bits. Informational only, since add/sub is format-agnostic; carried for assertions and bench scaling.
- SATURATE, 1, 1 = clamp to signed max/min on overflow; 0 = wrap (two's complement).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous and active-high: one clock; reset is synchronous and active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept operand beat.
- a_in  in  WIDTH  operand A, signed.
- b_in  in  WIDTH  operand B, signed. Ignored for accumulate ops.
- op  in  2  00 ADD (A+B), 01 SUB (A-B), 10 ACC_ADD (acc+A), 11 ACC_SUB (acc-A).
- acc_clr  in  1  treat accumulator as zero this cycle (see Behaviour).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  WIDTH  signed result.
- ovf  out  1  overflow occurred for the current result, qualified by out_valid.
- ovf_sticky  out  1  latched OR of all accepted-result overflows.
- sticky_clr  in  1  clear ovf_sticky.

Behaviour:
- Reset values: in_ready=1, out_valid=0, result=0, ovf=0, ovf_sticky=0; accumulator=0; all internal valids=0. Reset mid-operation discards all in-flight beats and does not emit them.
- Handshake: a beat transfers when valid&&ready on either side. Inputs a_in/b_in/op are sampled only on input transfer. Once out_valid=1, result, ovf and out_valid hold stable until out_ready.
- Pipeline has 2 stages.
  - S1 registers a, b, op and valid.
  - S2 computes the result, updates the accumulator and registers result/ovf/out_valid.
- Latency: exactly 2 cycles from input transfer to out_valid when unstalled. Throughput is 1 beat/cycle.
- Stall logic:
  - s2_adv = S1.valid && (!out_valid || out_ready).
  - in_ready = !S1.valid || s2_adv.
  - No bubbles are inserted under continuous out_ready=1.
- Arithmetic:
  - Sign-extend both operands to WIDTH+1 and compute the sum/difference.
  - ovf = wide[WIDTH] != wide[WIDTH-1].
  - If ovf and SATURATE=1: result = wide[WIDTH] ? signed min (1 followed by zeros) : signed max (0 followed by ones).
  - Otherwise result = wide[WIDTH-1:0].
- Accumulator (WIDTH bits):
  - Read and written only in S2, on s2_adv with op ACC_ADD/ACC_SUB. The new value equals the emitted result (saturated or wrapped per SATURATE).
  - Back-to-back acc ops chain correctly with no hazard.
  - ADD/SUB ops never modify the accumulator.
- acc_clr:
  - Sampled every cycle, independent of handshake.
  - If asserted with no acc op advancing in S2: accumulator becomes 0 next cycle.
  - If asserted in the same cycle an acc op advances in S2: that op uses 0 as its accumulator operand, so the accumulator loads +A / -A.
- ovf_sticky:
  - Set on any output transfer with ovf=1. Cleared by sticky_clr.
  - Set wins over clear in the same cycle.
- Wrap boundary, SATURATE=0: max + 1 gives min with ovf=1.
- Subtract boundary: 0 - min overflows; result is max (SATURATE=1) or min (SATURATE=0), with ovf=1.

Decomposition:
- Shared package fixed_point_pkg holds:
  - op enum (OP_ADD, OP_SUB, OP_ACC_ADD, OP_ACC_SUB);
  - default WIDTH/FRAC_BITS constants for Q24.8;
  - functions returning signed max/min for a given width.
- One natural combinational sub-module: fixed_point_sat_addsub (WIDTH, SATURATE; inputs x, y, sub; outputs result, ovf), instantiated in S2.

Test Plan:
- Basic add, Q24.8: a=0x00000180 (1.5), b=0x00000280 (2.5), ADD, out_ready=1 -> 2 cycles later result=0x00000400 (4.0), ovf=0.
- Overflow clamp, SATURATE=1: a=0x7FFFFF00, b=0x00000200, ADD -> result=0x7FFFFFFF, ovf=1, ovf_sticky=1. Same beat with SATURATE=0 -> result=0x80000100, ovf=1.
- Negative subtract: a=0xFFFFFF00 (-1.0), b=0x00000100 (1.0), SUB -> result=0xFFFFFE00 (-2.0), ovf=0. Then 0 - 0x80000000 -> result=0x7FFFFFFF, ovf=1.
- Accumulate chain: acc_clr pulse, then 4 back-to-back ACC_ADD with a=0x100 -> results 0x100, 0x200, 0x300, 0x400. Then ACC_SUB a=0x400 with acc_clr asserted as it reaches S2 -> result=0xFFFFFC00.
- Backpressure: stream 6 ADD beats with out_ready toggling in a random pattern -> no beat lost or duplicated, results in order, result held stable while out_valid&&!out_ready, in_ready=0 when both stages are full.
- Reset and sticky: assert rst with 2 beats in flight -> next cycle out_valid=0, acc=0, ovf_sticky=0. Overflow result transfer coinciding with sticky_clr -> ovf_sticky stays 1. Then a lone sticky_clr -> 0.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Shared types and constants for the Q-format add/sub pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fixed_point_pkg;

    // Per-beat operation select.
    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ACC_ADD = 2'b10,
        OP_ACC_SUB = 2'b11
    } op_e;

    // Default format is Q24.8.
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_FRAC_BITS = 8;

    // Widest word the max/min helpers can describe.
    localparam int MAX_HELPER_W  = 64;

    // Largest signed value of a w-bit word (0 followed by ones), right-aligned.
    function automatic logic [MAX_HELPER_W-1:0] signed_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Smallest signed value of a w-bit word (1 followed by zeros), right-aligned.
    function automatic logic [MAX_HELPER_W-1:0] signed_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

    // Accumulate ops use the running accumulator as their left operand.
    function automatic logic is_acc_op(input op_e o);
        return (o == OP_ACC_ADD) || (o == OP_ACC_SUB);
    endfunction

    // SUB and ACC_SUB subtract the right operand.
    function automatic logic is_sub_op(input op_e o);
        return (o == OP_SUB) || (o == OP_ACC_SUB);
    endfunction

endpackage

// File: rtl/fixed_point_sat_addsub.sv
// Signed add/sub of two WIDTH-bit words with overflow detect and optional clamp.
// Latency: combinational.
// Backpressure: none (pure datapath, no handshake).
module fixed_point_sat_addsub
    import fixed_point_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int SATURATE = 1
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam logic [MAX_HELPER_W-1:0] MAX64 = signed_max(WIDTH);
    localparam logic [MAX_HELPER_W-1:0] MIN64 = signed_min(WIDTH);
    localparam logic [WIDTH-1:0]        MAX_V = MAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0]        MIN_V = MIN64[WIDTH-1:0];

    logic [WIDTH:0] x_ext;
    logic [WIDTH:0] y_ext;
    logic [WIDTH:0] wide;

    // One guard bit is enough: sum/diff of two WIDTH-bit signed values fits in WIDTH+1.
    always_comb begin
        x_ext  = {x[WIDTH-1], x};
        y_ext  = {y[WIDTH-1], y};
        wide   = sub ? (x_ext - y_ext) : (x_ext + y_ext);
        ovf    = wide[WIDTH] ^ wide[WIDTH-1];
        result = wide[WIDTH-1:0];
        // The guard bit carries the true sign, so it picks which rail to clamp to.
        if (ovf && (SATURATE != 0)) begin
            result = wide[WIDTH] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/fixed_point_addsub_pipe.sv
// Two-stage Q-format add/sub with running accumulator, saturation and overflow flags.
// Latency: 2 cycles from in_valid to out_valid when unstalled; 1 beat/cycle throughput.
// Backpressure: out_ready low holds the output; S1 then fills and in_ready drops.
module fixed_point_addsub_pipe
    import fixed_point_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int SATURATE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [1:0]       op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             ovf_sticky,
    input  logic             sticky_clr
);

    // Stage 1: captured operands.
    logic             s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0] s1_a_q,   s1_a_d;
    logic [WIDTH-1:0] s1_b_q,   s1_b_d;
    op_e              s1_op_q,  s1_op_d;

    // Stage 2: registered result, accumulator and flags.
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             ovf_q,     ovf_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic             sticky_q,  sticky_d;

    // Handshake and datapath nets.
    logic             s2_adv;
    logic             in_xfer;
    logic             out_xfer;
    logic             s1_is_acc;
    logic [WIDTH-1:0] acc_opnd;
    logic [WIDTH-1:0] as_x;
    logic [WIDTH-1:0] as_y;
    logic             as_sub;
    logic [WIDTH-1:0] as_res;
    logic             as_ovf;

    // Flow control: S1 drains into S2 whenever the output slot is empty or leaving.
    always_comb begin
        s2_adv   = s1_vld_q && (!out_vld_q || out_ready);
        in_ready = !s1_vld_q || s2_adv;
        in_xfer  = in_valid && in_ready;
        out_xfer = out_vld_q && out_ready;
    end

    // Operand selection for S2; acc_clr forces a zero accumulator operand the same cycle,
    // which also covers the case where the accumulator was just written by the previous beat.
    always_comb begin
        s1_is_acc = is_acc_op(s1_op_q);
        acc_opnd  = acc_clr ? '0 : acc_q;
        as_x      = s1_is_acc ? acc_opnd : s1_a_q;
        as_y      = s1_is_acc ? s1_a_q   : s1_b_q;
        as_sub    = is_sub_op(s1_op_q);
    end

    fixed_point_sat_addsub #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_addsub (
        .x      (as_x),
        .y      (as_y),
        .sub    (as_sub),
        .result (as_res),
        .ovf    (as_ovf)
    );

    // S1 next state: load on input transfer, otherwise empty out once it has moved on.
    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_op_d  = s1_op_q;
        if (in_xfer) begin
            s1_vld_d = 1'b1;
            s1_a_d   = a_in;
            s1_b_d   = b_in;
            s1_op_d  = op_e'(op);
        end else if (s2_adv) begin
            s1_vld_d = 1'b0;
        end
    end

    // S2 next state: result/ovf only change when a new beat lands, so they hold under stall.
    always_comb begin
        out_vld_d = out_vld_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        if (s2_adv) begin
            out_vld_d = 1'b1;
            result_d  = as_res;
            ovf_d     = as_ovf;
        end else if (out_xfer) begin
            out_vld_d = 1'b0;
        end
    end

    // Accumulator tracks the emitted (clamped or wrapped) value of acc ops only.
    always_comb begin
        acc_d = acc_q;
        if (s2_adv && s1_is_acc) begin
            acc_d = as_res;
        end else if (acc_clr) begin
            acc_d = '0;
        end
    end

    // Sticky overflow: an overflowing result leaving the unit beats a same-cycle clear.
    always_comb begin
        sticky_d = sticky_q;
        if (out_xfer && ovf_q) begin
            sticky_d = 1'b1;
        end else if (sticky_clr) begin
            sticky_d = 1'b0;
        end
    end

    // Stage 1 registers; reset drops any captured beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_op_q  <= OP_ADD;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_op_q  <= s1_op_d;
        end
    end

    // Stage 2 registers; reset discards the pending result and clears all state.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            acc_q     <= '0;
            sticky_q  <= 1'b0;
        end else begin
            out_vld_q <= out_vld_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            acc_q     <= acc_d;
            sticky_q  <= sticky_d;
        end
    end

    assign out_valid  = out_vld_q;
    assign result     = result_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;

    // The fractional point must sit inside the word.
    a_frac_fits: assert property (@(posedge clk) (FRAC_BITS >= 0) && (FRAC_BITS < WIDTH));

    // A stalled result must not change or vanish before it is taken.
    a_out_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(result) && $stable(ovf)));

endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
module tb_fixed_point_addsub_pipe;
    import fixed_point_pkg::*;

    localparam int     W    = DEF_WIDTH;
    localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (W - 1));

    logic         clk = 1'b0;
    logic         rst, in_valid, acc_clr, out_ready, sticky_clr;
    logic [W-1:0] a_in, b_in;
    logic [1:0]   op;
    logic         in_ready_s, in_ready_w, out_valid_s, out_valid_w;
    logic         ovf_s, ovf_w, stk_s, stk_w;
    logic [W-1:0] res_s, res_w;

    always #5 clk = ~clk;

    fixed_point_addsub_pipe #(.WIDTH(W), .FRAC_BITS(DEF_FRAC_BITS), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a_in(a_in), .b_in(b_in), .op(op), .acc_clr(acc_clr),
        .out_valid(out_valid_s), .out_ready(out_ready), .result(res_s), .ovf(ovf_s),
        .ovf_sticky(stk_s), .sticky_clr(sticky_clr));

    fixed_point_addsub_pipe #(.WIDTH(W), .FRAC_BITS(DEF_FRAC_BITS), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .a_in(a_in), .b_in(b_in), .op(op), .acc_clr(acc_clr),
        .out_valid(out_valid_w), .out_ready(out_ready), .result(res_w), .ovf(ovf_w),
        .ovf_sticky(stk_w), .sticky_clr(sticky_clr));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int inflight = 0;
    bit mon_en  = 1'b0;
    bit rand_rdy = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: exact integer arithmetic, then range check against the word.
    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    exp_t   qs[$];
    exp_t   qw[$];
    longint acc_s = 0;
    longint acc_w = 0;

    function automatic exp_t ref_op(input longint x, input longint y, input bit sub, input bit sat);
        exp_t   e;
        longint s;
        s     = sub ? (x - y) : (x + y);
        e.ovf = (s > MAXV) || (s < MINV);
        if (e.ovf && sat) s = (s > MAXV) ? MAXV : MINV;
        e.res = s[W-1:0];
        return e;
    endfunction

    task automatic model_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [1:0] o, input bit clr);
        longint sa, sb;
        exp_t   es, ew;
        sa = $signed(a);
        sb = $signed(b);
        if (clr) begin
            acc_s = 0;
            acc_w = 0;
        end
        case (o)
            2'b00: begin es = ref_op(sa, sb, 0, 1); ew = ref_op(sa, sb, 0, 0); end
            2'b01: begin es = ref_op(sa, sb, 1, 1); ew = ref_op(sa, sb, 1, 0); end
            2'b10: begin es = ref_op(acc_s, sa, 0, 1); ew = ref_op(acc_w, sa, 0, 0); end
            default: begin es = ref_op(acc_s, sa, 1, 1); ew = ref_op(acc_w, sa, 1, 0); end
        endcase
        if (o[1]) begin
            acc_s = $signed(es.res);
            acc_w = $signed(ew.res);
        end
        qs.push_back(es);
        qw.push_back(ew);
    endtask

    // Present one beat; clr raises acc_clr for the cycle the beat sits in S1.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] o, input bit clr);
        int  waits;
        bit  ok;
        waits = 0;
        ok    = 1'b1;
        a_in = a; b_in = b; op = o; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready_s) break;
            waits++;
            if (waits > 200) begin
                chk("send_timeout", 64'd1, 64'd0);
                ok = 1'b0;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            model_beat(a, b, o, clr);
            inflight++;
            #1;
        end
        in_valid = 1'b0;
        acc_clr  = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            acc_clr = 1'b0;
        end
    endtask

    task automatic drain();
        int waits;
        waits = 0;
        while (qs.size() != 0 || qw.size() != 0) begin
            idle(1);
            waits++;
            if (waits > 500) begin
                chk("drain_timeout", 64'd1, 64'd0);
                qs.delete();
                qw.delete();
                inflight = 0;
                break;
            end
        end
        idle(1);
    endtask

    task automatic clr_pulse();
        acc_clr = 1'b1;
        acc_s   = 0;
        acc_w   = 0;
        idle(1);
    endtask

    // Output monitor: compare every presented result against the model, pop on transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (inflight == 2 && !out_ready) chk("in_ready_full", in_ready_s, 64'd0);
                if (out_valid_s) begin
                    if (qs.size() == 0) chk("spurious_out_sat", 64'd1, 64'd0);
                    else begin
                        chk("res_sat", res_s, qs[0].res);
                        chk("ovf_sat", ovf_s, qs[0].ovf);
                        if (out_ready) begin
                            void'(qs.pop_front());
                            inflight--;
                        end
                    end
                end
                if (out_valid_w) begin
                    if (qw.size() == 0) chk("spurious_out_wrap", 64'd1, 64'd0);
                    else begin
                        chk("res_wrap", res_w, qw[0].res);
                        chk("ovf_wrap", ovf_w, qw[0].ovf);
                        if (out_ready) void'(qw.pop_front());
                    end
                end
            end
        end
    end

    // Random downstream backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
            0:       v = W'($urandom);
            1:       v = 32'h7FFF_FF00 | W'($urandom_range(0, 255));
            2:       v = 32'h8000_0000 | W'($urandom_range(0, 255));
            default: v = W'($signed(12'($urandom)));
        endcase
        return v;
    endfunction

    initial begin
        int c0;
        bit seen;
        rst = 1'b1; in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
        a_in = '0; b_in = '0; op = 2'b00;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready_s, 64'd1);
        chk("rst_out_valid", out_valid_s, 64'd0);
        chk("rst_result", res_s, 64'd0);
        chk("rst_ovf", ovf_s, 64'd0);
        chk("rst_sticky", stk_s, 64'd0);
        idle(1);
        mon_en = 1'b1;

        // Basic Q24.8 add with latency check: 1.5 + 2.5 = 4.0.
        send(32'h0000_0180, 32'h0000_0280, OP_ADD, 0);
        @(negedge clk);
        chk("latency_c1", out_valid_s, 64'd0);
        @(negedge clk);
        chk("latency_c2", out_valid_s, 64'd1);
        drain();

        // Overflow clamp / wrap, sticky set.
        send(32'h7FFF_FF00, 32'h0000_0200, OP_ADD, 0);
        drain();
        chk("sticky_set_sat", stk_s, 64'd1);
        chk("sticky_set_wrap", stk_w, 64'd1);

        // Negative subtract, then 0 - min.
        send(32'hFFFF_FF00, 32'h0000_0100, OP_SUB, 0);
        send(32'h0000_0000, 32'h8000_0000, OP_SUB, 0);
        drain();

        // Accumulate chain at full rate, then ACC_SUB with acc_clr as it reaches S2.
        clr_pulse();
        c0 = cyc;
        for (int i = 0; i < 4; i++) send(32'h0000_0100, 32'h0, OP_ACC_ADD, 0);
        chk("acc_chain_rate", 64'(cyc - c0), 64'd4);
        send(32'h0000_0400, 32'h0, OP_ACC_SUB, 1);
        drain();

        // Backpressure stream: 6 ADDs, then mixed random traffic.
        rand_rdy = 1'b1;
        for (int i = 0; i < 6; i++) send(rand_operand(), rand_operand(), OP_ADD, 0);
        for (int i = 0; i < 80; i++) begin
            send(rand_operand(), rand_operand(), 2'($urandom_range(0, 3)), 0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(32'h0000_0011, 32'h0000_0022, OP_ADD, 0);
        send(32'h0000_0033, 32'h0000_0044, OP_SUB, 0);
        mon_en = 1'b0;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        out_ready = 1'b1;
        qs.delete(); qw.delete();
        inflight = 0; acc_s = 0; acc_w = 0;
        @(negedge clk);
        chk("rst_flight_out_valid", out_valid_s, 64'd0);
        chk("rst_flight_sticky", stk_s, 64'd0);
        chk("rst_flight_in_ready", in_ready_s, 64'd1);
        idle(2);
        chk("rst_flush_no_out", out_valid_s, 64'd0);
        mon_en = 1'b1;
        send(32'h0000_0005, 32'h0, OP_ACC_ADD, 0);
        drain();

        // Overflow transfer coinciding with sticky_clr: set wins.
        out_ready = 1'b0;
        send(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid_s;
        end
        chk("sticky_beat_arrives", seen, 64'd1);
        @(posedge clk);
        #1;
        out_ready  = 1'b1;
        sticky_clr = 1'b1;
        @(posedge clk);
        #1;
        sticky_clr = 1'b0;
        @(negedge clk);
        chk("sticky_set_wins_sat", stk_s, 64'd1);
        chk("sticky_set_wins_wrap", stk_w, 64'd1);
        sticky_clr = 1'b1;
        idle(1);
        sticky_clr = 1'b0;
        @(negedge clk);
        chk("sticky_clear_sat", stk_s, 64'd0);
        chk("sticky_clear_wrap", stk_w, 64'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
